transpose_buffer_ctrl: RTL
==========================

# transpose_buffer_ctrl

Row-in / column-out transpose buffer that stores a 9×9 block of 11-bit samples written one row per cycle and presents columns 2–5 to the downstream column-select mux. Also generates the mux `SELECT` sequence. It sits between the first (row) 1-D transform pass and the column-select stage feeding the second (column) pass. It is single-buffered: the block alternates between a FILL phase and a READ phase.

## Interface
Parameters:
- `SAMPLE_W`, 11: bits per sample.
- `N`, 9: rows and columns per block. `ROW_W = N*SAMPLE_W` = 99.

Ports (CLK, RST_N first). One clock; reset is asynchronous and active-low.
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: asynchronous active-low reset.
- `WR_VALID` in 1: `WR_ROW` holds a valid row.
- `WR_READY` out 1: buffer accepts a row; high only in FILL.
- `WR_ROW` in 99: one row. Sample 0 is in [98:88]; sample c is in [98-11c -: 11].
- `RD_VALID` out 1: columns and `SELECT` are valid; high only in READ.
- `RD_READY` in 1: the downstream stage consumes the currently selected column.
- `DATA_IN_2`..`DATA_IN_5` out 99 each: columns 2..5. Row 0 is in [98:88]; row r is in [98-11r -: 11].
- `SELECT` out 2: column index minus 2 (00→col 2 … 11→col 5).
- `DONE` out 1: one-cycle pulse when column 5 is consumed.

## Operation
- States: FILL (reset state) and READ.
- FILL
  - `WR_READY` = 1 and `RD_VALID` = 0.
  - A row is written when `WR_VALID` && `WR_READY`. It is stored at index `row_cnt`, then `row_cnt` increments.
  - When row 8 is accepted: `row_cnt` wraps to 0, the state goes to READ, and `SELECT` is set to 0.
- READ
  - `WR_READY` = 0; `WR_VALID` is ignored and storage does not change.
  - `RD_VALID` = 1.
  - On `RD_VALID` && `RD_READY`: `SELECT` increments.
  - When `SELECT` = 3 is consumed: pulse `DONE`, return to FILL, and set `SELECT` to 0.
- Column outputs are a pure rewiring of the storage: `DATA_IN_k` = {mem[0][k], mem[1][k], …, mem[8][k]}.
  - They change only when rows are written.
  - They are valid only while `RD_VALID` = 1.
- Columns 0, 1, 6, 7 and 8 are stored but not exported. The row pass delivers all 9 samples, so storage stays full-width.
- No arithmetic is performed; samples are passed bit-exact and unsigned.

## Timing
- Reset (asynchronous, on `RST_N` = 0):
  - State → FILL; `row_cnt` → 0; `SELECT` → 0; all storage → 0.
  - Outputs: `WR_READY` = 1, `RD_VALID` = 0, `DONE` = 0, `DATA_IN_2..5` = 0.
- Row 8 accepted at edge t → at t+1: `RD_VALID` = 1, `SELECT` = 0, and `DATA_IN_2..5` reflect the full block.
- Column consume: `RD_READY` sampled at edge t advances `SELECT` at t+1. `RD_READY` held high gives one column per cycle.
- Last consume (`SELECT` = 3) at edge t → at t+1: `DONE` = 1 for exactly one cycle, `WR_READY` = 1, `RD_VALID` = 0.
  - The earliest next write is at edge t+1.
  - Full turnaround for a block is 9 + 4 cycles.
- `RD_READY` low in READ: `SELECT` and the data hold indefinitely.
- `WR_VALID` low in FILL: `row_cnt` holds; gaps between rows are allowed.
- `WR_VALID` high during READ: no write, no counter change; the row must be held until `WR_READY`.
- Reset mid-FILL or mid-READ: the partial block is discarded, with no `DONE` pulse.
- `WR_READY` and `RD_VALID` are decoded from the registered state only. There are no combinational input→output paths apart from the storage→column wiring.

## Structure
- Shared package `transpose_pkg` holds:
  - `SAMPLE_W`, `N`, `ROW_W`, and `SEL_W` = 2.
  - The state encoding: FILL = 1'b0, READ = 1'b1.
  - A helper for column-slice indexing.
- Sub-module `transpose_buffer_regs`: the N×N storage array with row-write enable and row index in, and four 99-bit column buses out.
- The top level holds the FSM, `row_cnt`, `SELECT`, and `DONE`.

## Test plan
- Basic block: after reset, write rows with sample(r,c) = 16r+c, `RD_READY` = 1.
  - `RD_VALID` rises the cycle after row 8.
  - `DATA_IN_2` = {0x002, 0x012, …, 0x082}; `DATA_IN_5` = {0x005, …, 0x085}.
  - `SELECT` steps 0,1,2,3; `DONE` pulses once.
- Backpressure: `RD_READY` low for 5 cycles at `SELECT` = 1 → `SELECT` holds at 1 and `DATA_IN_3` holds. It resumes at 2 after `RD_READY` goes high.
- Write gaps / illegal write: `WR_VALID` toggles during FILL → exactly 9 rows are stored in order. `WR_VALID` = 1 with row 0x7FF…F during READ → storage is unchanged and `WR_READY` = 0.
- Back-to-back blocks: second block with sample = 0x400+16r+c written starting the cycle after `DONE` → its columns are correct. `row_cnt` wrapped, so no stale rows appear.
- Reset mid-operation: assert `RST_N` = 0 after row 4, and again at `SELECT` = 2 → all outputs return to reset values at once. A subsequent full block is correct and no spurious `DONE` occurs.

Source files
------------

// File: rtl/transpose_buffer_ctrl_pkg.sv
// Shared widths, FSM encoding and column-slice helper for the 9x9 transpose buffer.
// Used by the storage array and the control FSM.
package transpose_pkg;
    localparam int SAMPLE_W = 11;
    localparam int N        = 9;
    localparam int ROW_W    = N * SAMPLE_W;
    localparam int SEL_W    = 2;

    localparam logic [SEL_W-1:0] SEL_LAST = 2'd3;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_READ = 1'b1
    } state_e;

    // Element idx of a packed row/column sits MSB-first, so element 0 owns the top slice.
    function automatic int col_lsb(input int idx, input int n, input int w);
        return (n - 1 - idx) * w;
    endfunction
endpackage

// File: rtl/transpose_buffer_regs.sv
// NxN sample storage written one row per cycle; columns 2..5 are pure rewiring of the array.
// Write lands on the next edge; no backpressure, the caller gates wr_en.
module transpose_buffer_regs #(
    parameter  int SAMPLE_W = 11,
    parameter  int N        = 9,
    localparam int ROW_W    = N * SAMPLE_W,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [ROW_W-1:0] wr_row,
    output logic [ROW_W-1:0] col_2,
    output logic [ROW_W-1:0] col_3,
    output logic [ROW_W-1:0] col_4,
    output logic [ROW_W-1:0] col_5
);
    import transpose_pkg::*;

    logic [ROW_W-1:0] mem_q [N];
    logic [ROW_W-1:0] mem_d [N];

    always_comb begin
        for (int r = 0; r < N; r++) begin
            mem_d[r] = mem_q[r];
            if (wr_en && (wr_idx == IDX_W'(r))) begin
                mem_d[r] = wr_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < N; r++) begin
                mem_q[r] <= mem_d[r];
            end
        end
    end

    // Row r of the column bus takes sample k of stored row r.
    always_comb begin
        col_2 = '0;
        col_3 = '0;
        col_4 = '0;
        col_5 = '0;
        for (int r = 0; r < N; r++) begin
            col_2[col_lsb(r, N, SAMPLE_W) +: SAMPLE_W] = mem_q[r][col_lsb(2, N, SAMPLE_W) +: SAMPLE_W];
            col_3[col_lsb(r, N, SAMPLE_W) +: SAMPLE_W] = mem_q[r][col_lsb(3, N, SAMPLE_W) +: SAMPLE_W];
            col_4[col_lsb(r, N, SAMPLE_W) +: SAMPLE_W] = mem_q[r][col_lsb(4, N, SAMPLE_W) +: SAMPLE_W];
            col_5[col_lsb(r, N, SAMPLE_W) +: SAMPLE_W] = mem_q[r][col_lsb(5, N, SAMPLE_W) +: SAMPLE_W];
        end
    end
endmodule

// File: rtl/transpose_buffer_ctrl.sv
// Single-buffered row-in/column-out transpose: FILL 9 rows, then READ columns 2..5 via SELECT.
// READ starts the cycle after row 8; WR_READY low during READ, SELECT holds while RD_READY low.
module transpose_buffer_ctrl #(
    parameter  int SAMPLE_W = 11,
    parameter  int N        = 9,
    localparam int ROW_W    = N * SAMPLE_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [ROW_W-1:0] WR_ROW,
    output logic             RD_VALID,
    input  logic             RD_READY,
    output logic [ROW_W-1:0] DATA_IN_2,
    output logic [ROW_W-1:0] DATA_IN_3,
    output logic [ROW_W-1:0] DATA_IN_4,
    output logic [ROW_W-1:0] DATA_IN_5,
    output logic [1:0]       SELECT,
    output logic             DONE
);
    import transpose_pkg::*;

    localparam int               IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;
    logic             wr_en;

    assign wr_en = WR_VALID && (state_q == ST_FILL);

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (wr_en) begin
                    if (row_cnt_q == ROW_LAST) begin
                        row_cnt_d = '0;
                        sel_d     = '0;
                        state_d   = ST_READ;
                    end else begin
                        row_cnt_d = row_cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (RD_READY) begin
                    if (sel_q == SEL_LAST) begin
                        sel_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_FILL;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_FILL;
            row_cnt_q <= '0;
            sel_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
        end
    end

    assign WR_READY = (state_q == ST_FILL);
    assign RD_VALID = (state_q == ST_READ);
    assign SELECT   = sel_q;
    assign DONE     = done_q;

    transpose_buffer_regs #(
        .SAMPLE_W (SAMPLE_W),
        .N        (N)
    ) u_regs (
        .clk    (CLK),
        .rst_n  (RST_N),
        .wr_en  (wr_en),
        .wr_idx (row_cnt_q),
        .wr_row (WR_ROW),
        .col_2  (DATA_IN_2),
        .col_3  (DATA_IN_3),
        .col_4  (DATA_IN_4),
        .col_5  (DATA_IN_5)
    );
endmodule
